// File: rtl/tile_vec_feeder_if.sv
// Beat-stream input and tile-handshake output of the vector tile feeder.
// The feeder sits on the slave side; the producer/consumer pair drives the master side.
interface tile_vec_feeder_if #(
   parameter int WIDTH         = 16,
   parameter int PARALLEL_SIZE = 2,
   parameter int TILE_SIZE     = 128,
   parameter int LANES         = 8
);
   logic                                                     in_valid_i;
   logic                                                     in_ready_o;
   logic [LANES-1:0][WIDTH-1:0]                              in_data_i;
   logic                                                     in_last_i;
   logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                      in_scal_i;
   logic                                                     out_valid_o;
   logic                                                     out_ready_i;
   logic [1:0][PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0]  vec_o;
   logic [PARALLEL_SIZE-1:0][WIDTH-1:0]                      no_vec_o;

   modport slave (
      input  in_valid_i, in_data_i, in_last_i, in_scal_i, out_ready_i,
      output in_ready_o, out_valid_o, vec_o, no_vec_o
   );

   modport master (
      output in_valid_i, in_data_i, in_last_i, in_scal_i, out_ready_i,
      input  in_ready_o, out_valid_o, vec_o, no_vec_o
   );
endinterface

// File: rtl/tile_vec_feeder.sv
// Ping-pong tile assembler: narrow beats fill one bank while the other bank
// holds a complete pair of operand tiles plus per-lane scalar for stage2.
module tile_vec_feeder #(
   parameter int WIDTH         = 16,
   parameter int PARALLEL_SIZE = 2,
   parameter int TILE_SIZE     = 128,
   parameter int LANES         = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   tile_vec_feeder_if.slave   bus,
   output logic [15:0]        tiles_done_o,
   output logic               err_o
);
   localparam int BPL   = TILE_SIZE / LANES;
   localparam int BEATS = 2 * PARALLEL_SIZE * BPL;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1;
   localparam int EW    = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   // bank, operand, lane, element
   logic [1:0][1:0][PARALLEL_SIZE-1:0][TILE_SIZE-1:0][WIDTH-1:0] bank_vec;
   logic [1:0][PARALLEL_SIZE-1:0][WIDTH-1:0]                     bank_scal;

   logic [CW-1:0] beat_cnt;
   logic [1:0]    full_cnt;
   logic          wr_bank;
   logic          rd_bank;
   logic          run_q;

   logic          accept;
   logic          pop;
   logic          last_beat;
   logic          fill_done;
   logic          s_idx;
   logic [PW-1:0] p_idx;
   logic [EW-1:0] e_base;
   int            cnt_int;

   assign last_beat       = (beat_cnt == CW'(BEATS - 1));
   assign bus.in_ready_o  = run_q & (full_cnt != 2'd2) & ~flush_i;
   assign accept          = bus.in_valid_i & bus.in_ready_o;
   assign fill_done       = accept & last_beat;
   assign bus.out_valid_o = (full_cnt != 2'd0);
   assign pop             = bus.out_valid_o & bus.out_ready_i & ~flush_i;
   assign bus.vec_o       = bank_vec[rd_bank];
   assign bus.no_vec_o    = bank_scal[rd_bank];

   // Decode the beat counter into operand / lane / element-offset of the write target
   always_comb begin
      cnt_int = int'(beat_cnt);
      s_idx   = 1'(cnt_int / (BPL * PARALLEL_SIZE));
      p_idx   = PW'((cnt_int / BPL) % PARALLEL_SIZE);
      e_base  = EW'((cnt_int % BPL) * LANES);
   end

   // Bank storage: each accepted beat lands in the fill bank; scalar captured on beat 0
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bank_vec  <= '0;
         bank_scal <= '0;
      end else if (accept) begin
         for (int l = 0; l < LANES; l++) begin
            bank_vec[wr_bank][s_idx][p_idx][e_base + EW'(l)] <= bus.in_data_i[LW'(l)];
         end
         if (beat_cnt == '0) begin
            bank_scal[wr_bank] <= bus.in_scal_i;
         end
      end
   end

   // Input ready is held low until the first clock after reset release
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   // Fill side: beat counter and write-bank pointer
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         beat_cnt <= '0;
         wr_bank  <= 1'b0;
      end else if (flush_i) begin
         beat_cnt <= '0;
         wr_bank  <= 1'b0;
      end else if (accept) begin
         if (last_beat) begin
            beat_cnt <= '0;
            wr_bank  <= ~wr_bank;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   // Drain side: occupancy, read-bank pointer and consumed-tile count
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         full_cnt     <= 2'd0;
         rd_bank      <= 1'b0;
         tiles_done_o <= 16'd0;
      end else if (flush_i) begin
         full_cnt <= 2'd0;
         rd_bank  <= 1'b0;
      end else begin
         if (pop) begin
            rd_bank      <= ~rd_bank;
            tiles_done_o <= tiles_done_o + 16'd1;
         end
         case ({fill_done, pop})
            2'b10:   full_cnt <= full_cnt + 2'd1;
            2'b01:   full_cnt <= full_cnt - 2'd1;
            default: full_cnt <= full_cnt;
         endcase
      end
   end

   // Sticky framing error: in_last_i must coincide exactly with the final beat
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_o <= 1'b0;
      end else if (accept && (bus.in_last_i != last_beat)) begin
         err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_tile_vec_feeder.sv
// Directed bench for tile_vec_feeder with a tile scoreboard.
module tb_tile_vec_feeder;
   localparam int W     = 16;
   localparam int PS    = 2;
   localparam int TS    = 128;
   localparam int L     = 8;
   localparam int BPL   = TS / L;
   localparam int BEATS = 2 * PS * BPL;

   typedef logic [PS-1:0][W-1:0] scal_t;
   typedef struct {
      int    seed;
      scal_t scal;
   } tile_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic [15:0] tiles_done;
   logic        err;

   tile_t sb[$];
   int    n_chk    = 0;
   int    n_fail   = 0;
   int    exp_done = 0;
   scal_t s_a;

   always #5 clk = ~clk;

   tile_vec_feeder_if #(.WIDTH(W), .PARALLEL_SIZE(PS), .TILE_SIZE(TS), .LANES(L)) bus ();

   tile_vec_feeder #(.WIDTH(W), .PARALLEL_SIZE(PS), .TILE_SIZE(TS), .LANES(L)) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .flush_i      (flush),
      .bus          (bus),
      .tiles_done_o (tiles_done),
      .err_o        (err)
   );

   // element l of beat k for a given tile seed; seed 0 gives the plain {8{k}} pattern
   function automatic logic [W-1:0] elem(int seed, int k, int l);
      if (seed == 0) return W'(k);
      return W'((seed << 10) | (l << 6) | k);
   endfunction

   function automatic scal_t mk_scal(int seed);
      scal_t s;
      for (int p = 0; p < PS; p++) s[p] = W'(seed * 16 + p * 3 + 1);
      return s;
   endfunction

   // count elements of vec_o that differ from the expected tile (or from zero)
   function automatic int vec_diff(int seed, bit zero);
      int n = 0;
      logic [W-1:0] e;
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < PS; p++)
            for (int i = 0; i < TS; i++) begin
               e = zero ? '0 : elem(seed, s * PS * BPL + p * BPL + i / L, i % L);
               if (bus.vec_o[s][p][i] !== e) n++;
            end
      return n;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(int seed, int k, bit last, scal_t scal);
      int guard = 0;
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      for (int l = 0; l < L; l++) bus.in_data_i[l] = elem(seed, k, l);
      bus.in_last_i = last;
      bus.in_scal_i = (k == 0) ? scal : ~scal;
      while (bus.in_ready_o !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) chk("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      bus.in_last_i  = 1'b0;
   endtask

   task automatic send_range(int seed, int from, int to, int err_beat);
      for (int k = from; k <= to; k++)
         send_beat(seed, k, (k == BEATS - 1) || (k == err_beat), mk_scal(seed));
   endtask

   task automatic pop_check(string tag, bit thru);
      tile_t e;
      @(negedge clk);
      chk({tag, "_valid"}, bus.out_valid_o, 1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_vec"}, vec_diff(e.seed, 1'b0), 0);
         chk({tag, "_scal"}, bus.no_vec_o, e.scal);
      end
      bus.out_ready_i = 1'b1;
      if (thru) begin
         #1;
         chk({tag, "_no_ready_through"}, bus.in_ready_o, 0);
      end
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      exp_done++;
      chk({tag, "_done"}, tiles_done, 64'(exp_done & 16'hFFFF));
   endtask

   task automatic do_flush(bit with_pop);
      @(negedge clk);
      flush = 1'b1;
      bus.out_ready_i = with_pop;
      #1;
      chk("flush_ready_low", bus.in_ready_o, 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.out_ready_i = 1'b0;
      sb.delete();
   endtask

   task automatic reset_check(string tag);
      chk({tag, "_in_ready"}, bus.in_ready_o, 0);
      chk({tag, "_out_valid"}, bus.out_valid_o, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_done"}, tiles_done, 0);
      chk({tag, "_vec_zero"}, vec_diff(0, 1'b1), 0);
      chk({tag, "_scal_zero"}, bus.no_vec_o, 0);
   endtask

   task automatic tile_with_latency(string tag, int seed, scal_t scal);
      sb.push_back(tile_t'{seed: seed, scal: scal});
      for (int k = 0; k < BEATS - 1; k++) send_beat(seed, k, 1'b0, scal);
      chk({tag, "_valid_before_last"}, bus.out_valid_o, 0);
      send_beat(seed, BEATS - 1, 1'b1, scal);
      chk({tag, "_valid_after_last"}, bus.out_valid_o, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tile_t e;
      s_a[1] = 16'h000A;
      s_a[0] = 16'h000B;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.in_last_i   = 1'b0;
      bus.in_scal_i   = '0;
      bus.out_ready_i = 1'b0;

      // reset state
      #1 rst_n = 1'b0;
      #1 reset_check("rst");
      repeat (3) @(posedge clk);
      #1 chk("rst_ready_held", bus.in_ready_o, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_release", bus.in_ready_o, 1);

      // single tile, {8{k}} beats
      tile_with_latency("t0", 0, s_a);
      chk("t0_elem_1_1_127", bus.vec_o[1][1][127], 63);
      chk("t0_elem_0_0_0", bus.vec_o[0][0][0], 0);
      chk("t0_scal1", bus.no_vec_o[1], 16'h000A);
      chk("t0_err", err, 0);
      pop_check("t0", 1'b0);
      chk("t0_empty_after_pop", bus.out_valid_o, 0);

      // two tiles with consumer stalled: both banks fill, ready drops
      sb.push_back(tile_t'{seed: 1, scal: mk_scal(1)});
      send_range(1, 0, BEATS - 1, -1);
      sb.push_back(tile_t'{seed: 2, scal: mk_scal(2)});
      send_range(2, 0, BEATS - 1, -1);
      chk("full_ready_low", bus.in_ready_o, 0);
      chk("full_valid", bus.out_valid_o, 1);
      pop_check("t1", 1'b1);
      chk("ready_after_pop", bus.in_ready_o, 1);

      // tile 3 completes on the same edge that pops tile 2
      sb.push_back(tile_t'{seed: 3, scal: mk_scal(3)});
      send_range(3, 0, BEATS - 2, -1);
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      for (int l = 0; l < L; l++) bus.in_data_i[l] = elem(3, BEATS - 1, l);
      bus.in_last_i   = 1'b1;
      bus.out_ready_i = 1'b1;
      e = sb.pop_front();
      chk("t2_vec", vec_diff(e.seed, 1'b0), 0);
      chk("t2_scal", bus.no_vec_o, e.scal);
      chk("simul_ready", bus.in_ready_o, 1);
      @(posedge clk);
      #1;
      bus.in_valid_i  = 1'b0;
      bus.in_last_i   = 1'b0;
      bus.out_ready_i = 1'b0;
      exp_done++;
      chk("simul_done", tiles_done, 64'(exp_done));
      chk("simul_valid", bus.out_valid_o, 1);
      chk("simul_ready_after", bus.in_ready_o, 1);
      pop_check("t3", 1'b0);
      chk("t3_empty_after_pop", bus.out_valid_o, 0);

      // misplaced in_last_i on beat 10
      send_range(4, 0, 9, -1);
      chk("err_before", err, 0);
      send_range(4, 10, 10, 10);
      chk("err_set", err, 1);
      send_range(4, 11, BEATS - 1, 10);
      chk("err_tile_completes", bus.out_valid_o, 1);
      do_flush(1'b1);
      chk("flush_valid", bus.out_valid_o, 0);
      chk("flush_err_kept", err, 1);
      chk("flush_pop_ignored", tiles_done, 64'(exp_done));

      // flush mid-fill, then a fresh tile
      send_range(5, 0, 29, -1);
      do_flush(1'b0);
      chk("flush2_valid", bus.out_valid_o, 0);
      tile_with_latency("t6", 6, mk_scal(6));
      chk("err_sticky", err, 1);
      pop_check("t6", 1'b0);

      // async reset in the middle of a fill
      send_range(7, 0, 19, -1);
      #2 rst_n = 1'b0;
      #1 reset_check("midrst");
      sb.delete();
      exp_done = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("midrst_ready_after_release", bus.in_ready_o, 1);
      tile_with_latency("t8", 0, s_a);
      chk("t8_elem_1_1_127", bus.vec_o[1][1][127], 63);
      chk("t8_scal1", bus.no_vec_o[1], 16'h000A);
      pop_check("t8", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
